// File: rtl/rv_iter_exec.sv
`default_nettype none
// ============================================================================
// Module      : rv_iter_exec
// Description : Multi-cycle RV32I/RV64I integer ALU execute stage. Handles
//               I-type (immediate operand) and R-type (rv2 operand) ops.
//               Non-shift ops finish one cycle after acceptance. Shifts run
//               iteratively, at most SHIFT_STEP bit positions per cycle.
//               Valid/ready handshakes on the input and output sides; only
//               one operation is in flight at a time.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               in_valid / in_ready  - operation handshake (from decode)
//               funct3, alt,         - operation select (alt = instr bit 30)
//               is_rtype             - 1: B = rv2, 0: B = imm
//               rv1, rv2, imm        - operands
//               out_valid/out_ready  - result handshake (to writeback)
//               result               - rd value, stable while out_valid
//               busy                 - high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module rv_iter_exec #(
    parameter int   XLEN       = 32,
    parameter int   SHIFT_STEP = 4,
    localparam int  SHW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  logic            is_rtype,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] rv2,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;

    localparam logic [2:0] C_F3_ADD  = 3'b000;
    localparam logic [2:0] C_F3_SLL  = 3'b001;
    localparam logic [2:0] C_F3_SLT  = 3'b010;
    localparam logic [2:0] C_F3_SLTU = 3'b011;
    localparam logic [2:0] C_F3_XOR  = 3'b100;
    localparam logic [2:0] C_F3_SR   = 3'b101;
    localparam logic [2:0] C_F3_OR   = 3'b110;
    localparam logic [2:0] C_F3_AND  = 3'b111;

    // One extra bit so that SHIFT_STEP == XLEN is still representable.
    localparam logic [SHW:0] C_STEP = (SHW+1)'(SHIFT_STEP);

    logic [1:0]      state_q,  state_d;
    logic [XLEN-1:0] result_q, result_d;   // also the shift working register
    logic [SHW-1:0]  rem_q,    rem_d;      // shift positions still to do
    logic            left_q,   left_d;
    logic            sra_q,    sra_d;

    logic [XLEN-1:0] w_b;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_shift;
    logic [XLEN-1:0] w_alu;
    logic [SHW:0]    w_step;
    logic [SHW-1:0]  w_rem_next;
    logic [XLEN-1:0] w_shifted;

    assign w_b        = is_rtype ? rv2 : imm;
    assign w_shamt    = w_b[SHW-1:0];
    assign w_is_shift = (funct3 == C_F3_SLL) || (funct3 == C_F3_SR);

    always_comb begin
        w_alu = rv1;
        case (funct3)
            C_F3_ADD:  w_alu = (is_rtype && alt) ? (rv1 - w_b) : (rv1 + w_b);
            C_F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(rv1) < $signed(w_b))};
            C_F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, (rv1 < w_b)};
            C_F3_XOR:  w_alu = rv1 ^ w_b;
            C_F3_OR:   w_alu = rv1 | w_b;
            C_F3_AND:  w_alu = rv1 & w_b;
            default:   w_alu = rv1;  // shifts are handled by the SHIFT state
        endcase
    end

    // Step size is min(SHIFT_STEP, remaining); never exceeds rem_q, so the
    // truncation back to SHW bits below is lossless.
    assign w_step     = ({1'b0, rem_q} < C_STEP) ? {1'b0, rem_q} : C_STEP;
    assign w_rem_next = rem_q - w_step[SHW-1:0];

    // The working register's MSB is the original sign bit throughout an
    // arithmetic shift, so >>> on it fills correctly on every step.
    always_comb begin
        if (left_q) begin
            w_shifted = result_q << w_step;
        end else if (sra_q) begin
            w_shifted = $signed(result_q) >>> w_step;
        end else begin
            w_shifted = result_q >> w_step;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        left_d   = left_q;
        sra_d    = sra_q;
        case (state_q)
            C_IDLE: begin
                if (in_valid && in_ready) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        state_d  = C_SHIFT;
                        result_d = rv1;
                        rem_d    = w_shamt;
                        left_d   = (funct3 == C_F3_SLL);
                        sra_d    = (funct3 == C_F3_SR) && alt;
                    end else begin
                        // Zero-amount shifts fall through w_alu's default (rv1).
                        state_d  = C_DONE;
                        result_d = w_alu;
                    end
                end
            end
            C_SHIFT: begin
                result_d = w_shifted;
                rem_d    = w_rem_next;
                if (w_rem_next == '0) begin
                    state_d = C_DONE;
                end
            end
            C_DONE: begin
                if (out_ready) begin
                    state_d = C_IDLE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= C_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            left_q   <= 1'b0;
            sra_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            sra_q    <= sra_d;
        end
    end

    assign in_ready  = (state_q == C_IDLE) && !reset;
    assign out_valid = (state_q == C_DONE);
    assign busy      = (state_q != C_IDLE);
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_iter_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_iter_exec
// Description : Self-checking bench for rv_iter_exec. A 32-bit instance runs
//               a table of directed vectors plus backpressure and
//               reset-during-shift sequences; a 64-bit instance runs a
//               full-width arithmetic shift.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_iter_exec;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
    logic [2:0]  funct3 = '0;
    logic        alt = 1'b0, is_rtype = 1'b0;
    logic [31:0] rv1 = '0, rv2 = '0, imm = '0, result;

    // 64-bit instance
    logic        v64_in_valid = 1'b0, v64_in_ready, v64_out_valid, v64_out_ready = 1'b0, v64_busy;
    logic [2:0]  v64_funct3 = '0;
    logic        v64_alt = 1'b0, v64_is_rtype = 1'b0;
    logic [63:0] v64_rv1 = '0, v64_rv2 = '0, v64_imm = '0, v64_result;

    rv_iter_exec #(.XLEN(32), .SHIFT_STEP(4)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .alt(alt), .is_rtype(is_rtype),
        .rv1(rv1), .rv2(rv2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    rv_iter_exec #(.XLEN(64), .SHIFT_STEP(4)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .funct3(v64_funct3), .alt(v64_alt), .is_rtype(v64_is_rtype),
        .rv1(v64_rv1), .rv2(v64_rv2), .imm(v64_imm),
        .out_valid(v64_out_valid), .out_ready(v64_out_ready), .result(v64_result), .busy(v64_busy)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        alt;
        logic        rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Offer one op to the 32-bit instance and follow it to the output handshake.
    task automatic run_vec(input int idx, input vec_t v);
        int  lat;
        bit  hold_ok;
        @(negedge clk);
        check($sformatf("v%0d in_ready", idx), {63'd0, in_ready}, 64'd1);
        funct3 = v.f3; alt = v.alt; is_rtype = v.rt;
        rv1 = v.a; rv2 = v.b; imm = v.im;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        hold_ok = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (!busy || in_ready) hold_ok = 1'b0;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d result", idx), {32'd0, result}, {32'd0, v.exp});
        check($sformatf("v%0d busy_hold", idx), {63'd0, hold_ok}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check($sformatf("v%0d after_hs ov/busy", idx), {62'd0, out_valid, busy}, 64'd0);
    endtask

    initial begin
        //            f3     alt   rt    a             b             imm           exp           lat
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'd617,      32'd0,        32'd511,      32'd1128,     1}; // ADDI
        vecs[1]  = '{3'b000, 1'b1, 1'b1, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 1}; // SUB
        vecs[2]  = '{3'b010, 1'b0, 1'b0, 32'd989,      32'd0,        32'd295,      32'd0,        1}; // SLTI
        vecs[3]  = '{3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd0,        32'd1,        32'd1,        1}; // SLTI neg
        vecs[4]  = '{3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd0,        32'd1,        32'd0,        1}; // SLTIU
        vecs[5]  = '{3'b001, 1'b0, 1'b0, 32'd843,      32'd0,        32'd750,      32'h00D2C000, 5}; // SLLI 14
        vecs[6]  = '{3'b101, 1'b1, 1'b0, 32'hFFFFFFFB, 32'd0,        32'h403,      32'hFFFFFFFF, 2}; // SRAI 3
        vecs[7]  = '{3'b101, 1'b0, 1'b0, 32'd949,      32'd0,        32'd3,        32'd118,      2}; // SRLI 3
        vecs[8]  = '{3'b001, 1'b0, 1'b0, 32'h12345678, 32'd0,        32'd32,       32'h12345678, 1}; // shamt 0
        vecs[9]  = '{3'b100, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'hFF00FF00, 1}; // XOR alt=1
        vecs[10] = '{3'b110, 1'b0, 1'b1, 32'h0000FFFF, 32'h00FF0000, 32'd0,        32'h00FFFFFF, 1}; // OR
        vecs[11] = '{3'b111, 1'b0, 1'b0, 32'h12345678, 32'd0,        32'h0000FFFF, 32'h00005678, 1}; // ANDI
        vecs[12] = '{3'b000, 1'b1, 1'b0, 32'd10,       32'd0,        32'hFFFFFFFD, 32'd7,        1}; // ADDI alt ign
        vecs[13] = '{3'b101, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFE4, 32'd0,        32'hF8000000, 2}; // SRA 4
        vecs[14] = '{3'b101, 1'b0, 1'b1, 32'h80000000, 32'd31,       32'd0,        32'h00000001, 9}; // SRL 31
        vecs[15] = '{3'b001, 1'b1, 1'b1, 32'h00000001, 32'd31,       32'd0,        32'h80000000, 9}; // SLL 31
        vecs[16] = '{3'b000, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h00000000, 1}; // ADD wrap

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst in_ready", {63'd0, in_ready}, 64'd0);
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst result", {32'd0, result}, 64'd0);
        check("rst64 result", v64_result, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: result held while out_ready is low, new op waits.
        @(negedge clk);
        funct3 = 3'b000; alt = 1'b0; is_rtype = 1'b0;
        rv1 = 32'd617; imm = 32'd511; in_valid = 1'b1;
        @(posedge clk);
        #1 rv1 = 32'd1; imm = 32'd1;  // second op stays offered
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d ov/rdy", c), {62'd0, out_valid, in_ready}, 64'd2);
            check($sformatf("bp%0d result", c), {32'd0, result}, 64'd1128);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp after_hs ov/rdy", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp second ov", {63'd0, out_valid}, 64'd1);
        check("bp second result", {32'd0, result}, 64'd2);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the 2nd SHIFT cycle of SLL by 31.
        @(negedge clk);
        funct3 = 3'b001; alt = 1'b0; is_rtype = 1'b1;
        rv1 = 32'd1; rv2 = 32'd31; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);   // 1st SHIFT cycle
        @(negedge clk);   // 2nd SHIFT cycle
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid busy", {63'd0, busy}, 64'd0);
        check("rstmid out_valid", {63'd0, out_valid}, 64'd0);
        check("rstmid result", {32'd0, result}, 64'd0);
        check("rstmid in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            bit stale = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (out_valid || busy) stale = 1'b1;
            end
            check("rstmid no_stale", {63'd0, stale}, 64'd0);
        end

        // 64-bit: SRA 0x8000000000000000 by 63.
        @(negedge clk);
        check("v64 in_ready", {63'd0, v64_in_ready}, 64'd1);
        v64_funct3 = 3'b101; v64_alt = 1'b1; v64_is_rtype = 1'b0;
        v64_rv1 = 64'h8000_0000_0000_0000; v64_imm = 64'd63; v64_in_valid = 1'b1;
        @(posedge clk);
        #1 v64_in_valid = 1'b0;
        begin
            int lat = 0;
            while (lat < 60) begin
                @(negedge clk);
                lat++;
                if (v64_out_valid) break;
            end
            check("v64 latency", 64'(lat), 64'd17);
            check("v64 result", v64_result, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        v64_out_ready = 1'b1;
        @(posedge clk);
        #1 v64_out_ready = 1'b0;
        check("v64 after_hs ov", {63'd0, v64_out_valid}, 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
